// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } conv_state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential signed binary to packed-BCD converter (shift-and-add-3), start/done handshake.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NDIG   = 3,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd,
    output logic              neg,
    output logic              tens_nz
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);

    if (!((64'd10 ** NDIG) > (64'd1 << WIDTH))) begin : g_bad_ndig
        $error("bin2bcd_seq: NDIG too small for WIDTH (need 10**NDIG > 2**WIDTH)");
    end

    conv_state_t         state, state_nxt;
    logic [BW+WIDTH-1:0] sr;
    logic [BW+WIDTH-1:0] sr_shift;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt;
    logic                sign_r;
    logic                bin_neg;
    logic [WIDTH:0]      bin_ext;
    logic [WIDTH:0]      mag;

    // One extra bit so the most negative input negates to its true magnitude.
    always_comb begin
        bin_neg = SIGNED && bin[WIDTH-1];
        bin_ext = {bin_neg, bin};
        mag     = bin_neg ? ((~bin_ext) + {{WIDTH{1'b0}}, 1'b1}) : bin_ext;
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (sr[WIDTH+4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        sr_shift = {bcd_adj, sr[WIDTH-1:0]} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            cnt     <= '0;
            sign_r  <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            tens_nz <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // mag's MSB is always zero, so the load fills exactly BW+WIDTH bits.
                        sr     <= {{(BW-1){1'b0}}, mag};
                        sign_r <= bin_neg;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_shift;
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    bcd     <= sr[BW+WIDTH-1:WIDTH];
                    neg     <= sign_r;
                    tens_nz <= |sr[BW+WIDTH-1:WIDTH+4];
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
